// File: rtl/enc_capture_ctrl.sv
// Capture sequencer: arms the encoder counters, snapshots both 64-bit counts on each
// synchronized strobe rising edge and streams each snapshot as four 32-bit words.
module enc_capture_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        I_RST,
   input  logic        I_START,
   input  logic        I_STOP,
   input  logic [15:0] I_NSAMP,
   input  logic        I_SEL,
   input  logic [63:0] I_CNT_A0,
   input  logic [63:0] I_CNT_A1,
   input  logic        I_READY,
   output logic        O_ARM,
   output logic [31:0] O_DATA,
   output logic        O_VALID,
   output logic        O_LAST,
   output logic        O_BUSY,
   output logic        O_DONE,
   output logic        O_OVR,
   output logic [15:0] O_SCNT
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_SEND   = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   logic [1:0]             state;
   logic [SYNC_STAGES-1:0] sel_sync;
   logic                   sel_q;
   logic                   sel_rise;
   logic [63:0]            snap_a0;
   logic [63:0]            snap_a1;
   logic [1:0]             word_idx;
   logic [15:0]            nsamp;
   logic [15:0]            scnt;
   logic                   stop_pend;
   logic                   ovr;
   logic                   run_end;

   always_ff @(posedge CLK) begin
      if (I_RST) begin
         sel_sync <= '0;
         sel_q    <= 1'b0;
      end else begin
         sel_sync <= {sel_sync[SYNC_STAGES-2:0], I_SEL};
         sel_q    <= sel_sync[SYNC_STAGES-1];
      end
   end

   assign sel_rise = sel_sync[SYNC_STAGES-1] & ~sel_q;

   // A stop arriving on the same cycle as the final handshake still ends the run.
   assign run_end = stop_pend | I_STOP | ((nsamp != '0) && (scnt == nsamp));

   always_ff @(posedge CLK) begin
      if (I_RST) begin
         state     <= ST_IDLE;
         snap_a0   <= '0;
         snap_a1   <= '0;
         word_idx  <= '0;
         nsamp     <= '0;
         scnt      <= '0;
         stop_pend <= 1'b0;
         ovr       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               stop_pend <= 1'b0;
               if (I_START) begin
                  nsamp <= I_NSAMP;
                  scnt  <= '0;
                  ovr   <= 1'b0;
                  state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (sel_rise) begin
                  snap_a0  <= I_CNT_A0;
                  snap_a1  <= I_CNT_A1;
                  scnt     <= scnt + 16'd1;
                  word_idx <= '0;
                  state    <= ST_SEND;
                  if (I_STOP) stop_pend <= 1'b1;
               end else if (I_STOP) begin
                  state <= ST_FINISH;
               end
            end
            ST_SEND: begin
               if (sel_rise) ovr <= 1'b1;
               if (I_STOP) stop_pend <= 1'b1;
               if (I_READY) begin
                  word_idx <= word_idx + 2'd1;
                  if (word_idx == 2'd3) state <= run_end ? ST_FINISH : ST_ARMED;
               end
            end
            default: begin
               if (sel_rise) ovr <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      O_DATA = '0;
      if (state == ST_SEND) begin
         case (word_idx)
            2'd0:    O_DATA = snap_a0[31:0];
            2'd1:    O_DATA = snap_a0[63:32];
            2'd2:    O_DATA = snap_a1[31:0];
            default: O_DATA = snap_a1[63:32];
         endcase
      end
   end

   assign O_ARM   = (state == ST_ARMED) || (state == ST_SEND);
   assign O_VALID = (state == ST_SEND);
   assign O_LAST  = (state == ST_SEND) && (word_idx == 2'd3);
   assign O_BUSY  = (state != ST_IDLE);
   assign O_DONE  = (state == ST_FINISH);
   assign O_OVR   = ovr;
   assign O_SCNT  = scnt;

endmodule
